// File: rtl/i2c_master_bit_engine.sv
// I2C master bit engine: executes one bus symbol (start, stop, data bit, ACK/NACK)
// per command as four quarter-bit phases, with clock stretching and arbitration checks.
//
// state | meaning
// IDLE  | waiting for go; lines hold their last driven values
// P0    | first quarter: SCL low (start: SCL held), SDA set up
// P1    | SCL released; waits out slave stretching, then counts CLK_DIV
// P2    | SCL high; SDA sampled on the first cycle
// P3    | last quarter: SCL pulled low (stop: both lines released)
// DONE  | finish=1 until go drops
module i2c_master_bit_engine #(
    parameter int CLK_DIV     = 4,
    parameter int STRETCH_MAX = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic [2:0] command,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       finish,
    output logic       rx_bit,
    output logic       arb_lost,
    output logic       timeout
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int SW = (STRETCH_MAX > 1) ? $clog2(STRETCH_MAX + 1) : 1;
    localparam logic [CW-1:0] PHASE_LOAD   = CW'(CLK_DIV - 1);
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_MAX);

    localparam logic [2:0] CMD_NOP   = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;
    localparam logic [2:0] CMD_START = 3'b010;
    localparam logic [2:0] CMD_STOP  = 3'b011;
    localparam logic [2:0] CMD_WR0   = 3'b100;
    localparam logic [2:0] CMD_WR1   = 3'b101;
    localparam logic [2:0] CMD_ACK   = 3'b110;
    localparam logic [2:0] CMD_NACK  = 3'b111;

    typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, DONE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      cmd_q, cmd_eff;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   stretch_cnt;
    logic [1:0]      grace;
    logic            scl_m, scl_s, sda_m, sda_s;
    logic            scl_nxt, sda_nxt;
    logic            is_data, drive_low, scl_ok, stretching, phase_done;
    logic            first_p2, arb_hit, timeout_hit, abort;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Our own SCL release needs two cycles to show up through the synchroniser,
    // so the first two P1 cycles count as high and are never stretch cycles.
    always_comb begin
        cmd_eff     = (state == IDLE) ? command : cmd_q;
        is_data     = cmd_q[2] || (cmd_q == CMD_READ);
        drive_low   = (cmd_eff == CMD_WR0) || (cmd_eff == CMD_ACK);
        scl_ok      = (grace != 2'd0) || scl_s;
        stretching  = (state == P1) && !scl_ok;
        phase_done  = (cnt == '0) && ((state != P1) || scl_ok);
        first_p2    = (state == P2) && (cnt == PHASE_LOAD);
        arb_hit     = first_p2 && ((cmd_q == CMD_WR1) || (cmd_q == CMD_NACK)) && !sda_s;
        timeout_hit = (STRETCH_MAX > 0) && stretching && (stretch_cnt == SW'(1));
        abort       = arb_hit || timeout_hit;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (go) state_nxt = (command == CMD_NOP) ? DONE : P0;
            P0:   if (phase_done) state_nxt = P1;
            P1: begin
                if (timeout_hit)     state_nxt = DONE;
                else if (phase_done) state_nxt = P2;
            end
            P2: begin
                if (arb_hit)         state_nxt = DONE;
                else if (phase_done) state_nxt = P3;
            end
            P3:   if (phase_done) state_nxt = DONE;
            DONE: if (!go) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Line values are computed for the state being entered and registered,
    // so IDLE/DONE keep SCL low between symbols of a transfer.
    always_comb begin
        scl_nxt = scl_oe;
        sda_nxt = sda_oe;
        busy    = (state == P0) || (state == P1) || (state == P2) || (state == P3);
        finish  = (state == DONE);
        if (abort) begin
            scl_nxt = 1'b0;
            sda_nxt = 1'b0;
        end else begin
            case (state_nxt)
                P0: begin
                    if (cmd_eff == CMD_START) begin
                        sda_nxt = 1'b0;
                    end else if (cmd_eff == CMD_STOP) begin
                        scl_nxt = 1'b1;
                        sda_nxt = 1'b1;
                    end else begin
                        scl_nxt = 1'b1;
                        sda_nxt = drive_low;
                    end
                end
                P1: begin
                    scl_nxt = 1'b0;
                    if (cmd_eff == CMD_START)     sda_nxt = 1'b0;
                    else if (cmd_eff == CMD_STOP) sda_nxt = 1'b1;
                    else                          sda_nxt = drive_low;
                end
                P2: begin
                    scl_nxt = 1'b0;
                    if (cmd_eff == CMD_START)     sda_nxt = 1'b1;
                    else if (cmd_eff == CMD_STOP) sda_nxt = 1'b0;
                    else                          sda_nxt = drive_low;
                end
                P3: begin
                    if (cmd_eff == CMD_START) begin
                        scl_nxt = 1'b1;
                        sda_nxt = 1'b1;
                    end else if (cmd_eff == CMD_STOP) begin
                        scl_nxt = 1'b0;
                        sda_nxt = 1'b0;
                    end else begin
                        scl_nxt = 1'b1;
                        sda_nxt = drive_low;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scl_m       <= 1'b1;
            scl_s       <= 1'b1;
            sda_m       <= 1'b1;
            sda_s       <= 1'b1;
            scl_oe      <= 1'b0;
            sda_oe      <= 1'b0;
            rx_bit      <= 1'b0;
            arb_lost    <= 1'b0;
            timeout     <= 1'b0;
            cmd_q       <= CMD_NOP;
            cnt         <= '0;
            grace       <= 2'd0;
            stretch_cnt <= '0;
        end else begin
            scl_m  <= scl_i;
            scl_s  <= scl_m;
            sda_m  <= sda_i;
            sda_s  <= sda_m;
            scl_oe <= scl_nxt;
            sda_oe <= sda_nxt;

            if ((state == IDLE) && go) begin
                cmd_q    <= command;
                rx_bit   <= 1'b0;
                arb_lost <= 1'b0;
                timeout  <= 1'b0;
            end
            if (first_p2 && is_data) rx_bit <= sda_s;
            if (arb_hit)             arb_lost <= 1'b1;
            if (timeout_hit)         timeout <= 1'b1;

            if (state_nxt != state)
                cnt <= PHASE_LOAD;
            else if ((cnt != '0) && ((state != P1) || scl_ok))
                cnt <= cnt - 1'b1;

            if ((state_nxt == P1) && (state != P1)) begin
                grace       <= 2'd2;
                stretch_cnt <= STRETCH_LOAD;
            end else begin
                if (grace != 2'd0) grace <= grace - 2'd1;
                if (stretching && (stretch_cnt != '0)) stretch_cnt <= stretch_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_bit_engine.sv
// Bench for i2c_master_bit_engine: directed symbol sequences plus random commands,
// checked against a phase-table / wired-AND bus model.
module tb_i2c_master_bit_engine;

    localparam int CD = 4;

    logic       clock;
    logic       reset, go, go2;
    logic [2:0] command, command2;
    logic       scl_i, sda_i, scl_oe, sda_oe, busy, finish, rx_bit, arb_lost, timeout;
    logic       scl_i2, sda_i2, scl_oe2, sda_oe2, busy2, finish2, rx_bit2, arb_lost2, timeout2;
    logic       scl_hold, sda_force, scl_hold2;
    int         checks, failures;

    // Open-drain bus: a line is low if the master pulls it or the bench holds it.
    assign scl_i  = ~(scl_oe | scl_hold);
    assign sda_i  = ~(sda_oe | sda_force);
    assign scl_i2 = ~(scl_oe2 | scl_hold2);
    assign sda_i2 = ~sda_oe2;

    i2c_master_bit_engine #(.CLK_DIV(CD), .STRETCH_MAX(1024)) dut (
        .clock(clock), .reset(reset), .go(go), .command(command),
        .scl_i(scl_i), .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe),
        .busy(busy), .finish(finish), .rx_bit(rx_bit), .arb_lost(arb_lost), .timeout(timeout)
    );

    i2c_master_bit_engine #(.CLK_DIV(CD), .STRETCH_MAX(8)) dut_to (
        .clock(clock), .reset(reset), .go(go2), .command(command2),
        .scl_i(scl_i2), .sda_i(sda_i2), .scl_oe(scl_oe2), .sda_oe(sda_oe2),
        .busy(busy2), .finish(finish2), .rx_bit(rx_bit2), .arb_lost(arb_lost2), .timeout(timeout2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Expected {scl_oe, sda_oe} for phase ph (0..3) of command c.
    function automatic logic [1:0] model_lines(input logic [2:0] c, input int ph, input logic prev_scl);
        logic [1:0] r;
        logic       d;
        d = (c == 3'b100) || (c == 3'b110);
        if (c == 3'b010) begin
            if (ph == 0)      r = {prev_scl, 1'b0};
            else if (ph == 1) r = 2'b00;
            else if (ph == 2) r = 2'b01;
            else              r = 2'b11;
        end else if (c == 3'b011) begin
            if (ph == 0)      r = 2'b11;
            else if (ph == 1) r = 2'b01;
            else              r = 2'b00;
        end else begin
            r = {(ph == 0) || (ph == 3), d};
        end
        return r;
    endfunction

    // Issue one command from IDLE (called at a negedge) and check it end to end.
    task automatic run_cmd(input logic [2:0] c, input logic force_low, input int stretch, input string tag);
        logic [1:0] trace[$];
        logic [1:0] exp_done;
        logic       prev_scl, prev_sda, d, is_data, bus_sda, exp_arb;
        int         n, exp_len;
        prev_scl = scl_oe;
        prev_sda = sda_oe;
        is_data  = (c == 3'b001) || c[2];
        d        = (c == 3'b100) || (c == 3'b110);
        bus_sda  = !d && !force_low;
        exp_arb  = ((c == 3'b101) || (c == 3'b111)) && !bus_sda;
        sda_force = force_low;
        command   = c;
        go        = 1'b1;
        @(posedge clock);
        #1 command = 3'($urandom_range(0, 7));
        n = 0;
        @(negedge clock);
        while (busy === 1'b1 && n < 200) begin
            if (n == CD && stretch > 0) scl_hold = 1'b1;
            if (n == CD + stretch)      scl_hold = 1'b0;
            trace.push_back({scl_oe, sda_oe});
            n++;
            @(negedge clock);
        end
        scl_hold = 1'b0;

        if (c == 3'b000)  exp_len = 0;
        else if (exp_arb) exp_len = 2 * CD + 1 + stretch;
        else              exp_len = 4 * CD + stretch;
        if (stretch == 0) chk({tag, "_len"}, 32'(n), 32'(exp_len));
        else              chk_range({tag, "_len"}, n, exp_len, exp_len + 2);
        chk({tag, "_finish"}, 32'(finish), 32'(1));

        if (c != 3'b000 && n >= 2 * CD + 1) begin
            chk({tag, "_p0"}, 32'(trace[0]), 32'(model_lines(c, 0, prev_scl)));
            chk({tag, "_p1"}, 32'(trace[CD]), 32'(model_lines(c, 1, prev_scl)));
        end
        if (c != 3'b000 && !exp_arb && n >= 4 * CD) begin
            chk({tag, "_p2"}, 32'(trace[n - 2 * CD]), 32'(model_lines(c, 2, prev_scl)));
            chk({tag, "_p3"}, 32'(trace[n - 1]), 32'(model_lines(c, 3, prev_scl)));
        end

        if (c == 3'b000)  exp_done = {prev_scl, prev_sda};
        else if (exp_arb) exp_done = 2'b00;
        else              exp_done = model_lines(c, 3, prev_scl);
        chk({tag, "_done_lines"}, 32'({scl_oe, sda_oe}), 32'(exp_done));
        chk({tag, "_rx"}, 32'(rx_bit), 32'(is_data ? bus_sda : 1'b0));
        chk({tag, "_arb"}, 32'(arb_lost), 32'(exp_arb));
        chk({tag, "_timeout"}, 32'(timeout), 32'(0));

        @(negedge clock);
        chk({tag, "_finish_held"}, 32'({finish, rx_bit, arb_lost}),
            32'({1'b1, is_data ? bus_sda : 1'b0, exp_arb}));
        go = 1'b0;
        sda_force = 1'b0;
        @(negedge clock);
        chk({tag, "_idle"}, 32'({finish, busy, rx_bit, arb_lost}),
            32'({1'b0, 1'b0, is_data ? bus_sda : 1'b0, exp_arb}));
    endtask

    initial begin
        logic [2:0] c;
        logic       f;
        int         s, n;
        checks = 0; failures = 0;
        reset = 1'b1; go = 1'b0; go2 = 1'b0; command = 3'b000; command2 = 3'b000;
        scl_hold = 1'b0; sda_force = 1'b0; scl_hold2 = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_outputs", 32'({scl_oe, sda_oe, busy, finish, rx_bit, arb_lost, timeout}), 32'(0));
        reset = 1'b0;
        @(negedge clock);

        run_cmd(3'b010, 1'b0, 0, "start");
        run_cmd(3'b011, 1'b0, 0, "stop");
        run_cmd(3'b010, 1'b0, 0, "start2");
        run_cmd(3'b100, 1'b0, 0, "wr0");
        run_cmd(3'b101, 1'b0, 0, "wr1");
        run_cmd(3'b110, 1'b0, 0, "ack");
        run_cmd(3'b111, 1'b0, 0, "nack");
        run_cmd(3'b001, 1'b1, 0, "read_low");
        run_cmd(3'b001, 1'b0, 0, "read_high");
        run_cmd(3'b101, 1'b1, 0, "arb_wr1");
        run_cmd(3'b010, 1'b0, 0, "rstart");
        run_cmd(3'b100, 1'b0, 10, "stretch10");
        run_cmd(3'b000, 1'b0, 0, "nop");

        // Stretch timeout on the STRETCH_MAX=8 instance.
        command2 = 3'b100;
        go2 = 1'b1;
        @(posedge clock);
        n = 0;
        @(negedge clock);
        while (busy2 === 1'b1 && n < 200) begin
            if (n == CD)      scl_hold2 = 1'b1;
            if (n == CD + 10) scl_hold2 = 1'b0;
            n++;
            @(negedge clock);
        end
        scl_hold2 = 1'b0;
        chk_range("to_abort_len", n, CD + 8, CD + 10);
        chk("to_flags", 32'({finish2, timeout2, arb_lost2}), 32'(3'b110));
        chk("to_lines", 32'({scl_oe2, sda_oe2}), 32'(0));
        go2 = 1'b0;
        @(negedge clock);
        chk("to_idle_held", 32'({finish2, timeout2}), 32'(2'b01));

        // Reset during P2 of write 0.
        command = 3'b100;
        go = 1'b1;
        @(posedge clock);
        repeat (2 * CD + 2) @(negedge clock);
        chk("pre_reset_busy", 32'(busy), 32'(1));
        reset = 1'b1;
        go = 1'b0;
        @(negedge clock);
        chk("mid_reset_outputs", 32'({scl_oe, sda_oe, busy, finish, rx_bit, arb_lost, timeout}), 32'(0));
        reset = 1'b0;
        @(negedge clock);
        run_cmd(3'b101, 1'b0, 0, "post_reset_wr1");

        repeat (24) begin
            c = 3'($urandom_range(0, 7));
            f = ((c == 3'b001) || (c == 3'b101) || (c == 3'b111)) ? 1'($urandom_range(0, 1)) : 1'b0;
            s = (c != 3'b000 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
            run_cmd(c, f, s, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
